// File: rtl/riscv_wb_pkg.sv
// riscv_wb_pkg: shared writeback-stage encodings (result source select, load funct3 codes)
package riscv_wb_pkg;
    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_CSR = 2'b11
    } result_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
endpackage

// File: rtl/load_align.sv
// load_align: extracts and sign/zero-extends sub-word load data.
//   data   : naturally aligned memory word/doubleword
//   offset : byte offset of the access (bit 2 only meaningful for XLEN=64)
//   funct3 : load type
//   ext    : aligned, extended result
module load_align
    import riscv_wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] data,
    input  logic [2:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] ext
);
    logic [2:0]  off;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;

    // Halfword/word selects drop the low offset bits, so misaligned offsets
    // land on the containing naturally aligned field. LD, reserved 111, and
    // on RV32 the LW/LD/LWU word all reduce to the full data word.
    always_comb begin
        off = XLEN == 64 ? offset : {1'b0, offset[1:0]};
        b   = 8'(data >> {off, 3'b000});
        h   = 16'(data >> {off[2:1], 4'b0000});
        w   = 32'(data >> {off[2], 5'b00000});
        ext = funct3 == F3_LB  ? XLEN'($signed(b)) :
              funct3 == F3_LBU ? XLEN'(b) :
              funct3 == F3_LH  ? XLEN'($signed(h)) :
              funct3 == F3_LHU ? XLEN'(h) :
              funct3 == F3_LW  ? XLEN'($signed(w)) :
              funct3 == F3_LWU ? XLEN'(w) :
                                 data;
    end
endmodule

// File: rtl/writeback_stage_p.sv
// writeback_stage_p: result select, load alignment and registered writeback toward the register file.
//   inputs : valid/stall/flush control, reg_write, result source, funct3,
//            ALU result, load data, PC+4, CSR data, rd
//   outputs: registered result, write enable, rd, valid, retired-instruction count
module writeback_stage_p
    import riscv_wb_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic              stall_in,
    input  logic              flush_in,
    input  logic              reg_write_in,
    input  logic [1:0]        result_src_in,
    input  logic [2:0]        funct3_in,
    input  logic [XLEN-1:0]   alu_result_in,
    input  logic [XLEN-1:0]   read_data_in,
    input  logic [XLEN-1:0]   pc_plus4_in,
    input  logic [XLEN-1:0]   csr_data_in,
    input  logic [REG_AW-1:0] rd_in,
    output logic [XLEN-1:0]   result_out,
    output logic              reg_write_out,
    output logic [REG_AW-1:0] rd_out,
    output logic              valid_out,
    output logic [CNT_W-1:0]  instret_out
);
    logic [XLEN-1:0] load_val;
    logic [XLEN-1:0] result_d;
    logic            we_d;
    logic            retire;

    load_align #(.XLEN(XLEN)) u_align (
        .data   (read_data_in),
        .offset (alu_result_in[2:0]),
        .funct3 (funct3_in),
        .ext    (load_val)
    );

    always_comb begin
        result_d = result_src_in == RES_ALU ? alu_result_in :
                   result_src_in == RES_MEM ? load_val :
                   result_src_in == RES_PC4 ? pc_plus4_in :
                                              csr_data_in;
        // x0 is hardwired zero, so its write is suppressed but the slot still retires
        we_d     = reg_write_in & valid_in & (rd_in != '0);
        retire   = valid_in & ~stall_in & ~flush_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_out    <= '0;
            reg_write_out <= 1'b0;
            rd_out        <= '0;
            valid_out     <= 1'b0;
        end else if (flush_in) begin
            result_out    <= result_d;
            reg_write_out <= 1'b0;
            rd_out        <= rd_in;
            valid_out     <= 1'b0;
        end else if (!stall_in) begin
            result_out    <= result_d;
            reg_write_out <= we_d;
            rd_out        <= rd_in;
            valid_out     <= valid_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            instret_out <= '0;
        else if (retire)
            instret_out <= instret_out + CNT_W'(1);
    end
endmodule

// File: doc/writeback_stage_p.md
# writeback_stage_p

Parametrised RV32I/RV64I writeback stage, successor to the fixed 32-bit writeback register. It selects among four result sources and aligns and extends sub-word load data per funct3. It registers the result, destination and write-enable toward the register file and forwarding network, and supports pipeline stall, flush, valid tracking and x0 write suppression. It also keeps a retired-instruction counter. It sits between the memory-stage pipeline register and the register-file write port.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- REG_AW, 5, register address width.
- CNT_W, 64, width of the retired-instruction counter.

- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- valid_in  in  1  memory-stage slot holds a real instruction
- stall_in  in  1  hold all stage registers
- flush_in  in  1  kill the incoming slot
- reg_write_in  in  1  instruction writes rd
- result_src_in  in  2  00 ALU, 01 load, 10 PC+4, 11 CSR read data
- funct3_in  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, 011 LD, 110 LWU
- alu_result_in  in  XLEN  ALU result; bits [2:0] are the load byte offset
- read_data_in  in  XLEN  raw naturally-aligned memory word or doubleword
- pc_plus4_in  in  XLEN  link value
- csr_data_in  in  XLEN  CSR read value
- rd_in  in  REG_AW  destination register
- result_out  out  XLEN  registered writeback value
- reg_write_out  out  1  registered register-file write enable
- rd_out  out  REG_AW  registered destination
- valid_out  out  1  registered slot valid
- instret_out  out  CNT_W  retired-instruction count

## Operation
- Next-state inputs:
  - result: the source mux output; source 01 takes the load_align output.
  - write enable: `reg_write_in & valid_in & (rd_in != 0)`.
- Load alignment:
  - Byte: select `read_data_in[8*off +: 8]`, where off = alu_result_in[1:0] for XLEN=32 and [2:0] for XLEN=64.
  - Half: uses off with bit 0 ignored.
  - Word: for XLEN=64, uses off[2]; otherwise off is ignored.
  - LB/LH/LW sign-extend; LBU/LHU/LWU zero-extend.
  - With XLEN=32, LD and LWU are treated as LW.
  - Reserved funct3 111 is treated as the full-width load.
- Register update priority, each cycle:
  1. rst: all outputs cleared.
  2. flush_in: valid_out=0, reg_write_out=0; result_out and rd_out are loaded but unused. Flush overrides stall.
  3. stall_in: every output register holds its value.
  4. Otherwise: all registers load from the next-state inputs.
- instret counter:
  - Increments by 1 on any edge where a valid instruction loads (valid_in & !stall_in & !flush_in & !rst).
  - Wraps modulo 2^CNT_W.
  - Never decrements.
- Invalid slots (valid_in=0) load valid_out=0 and reg_write_out=0 and do not count.

## Timing
- Latency 1 cycle from inputs to every registered output; no combinational input→output path.
- Reset values: result_out=0, reg_write_out=0, rd_out=0, valid_out=0, instret_out=0.
- Reset mid-operation takes effect at the next edge and discards the in-flight slot.
- Stall and flush together resolve as a flush; instret is unchanged.
- Stall lasting N cycles: outputs stay stable for N cycles, and instret increments exactly once for the held instruction, at its original load edge.
- instret at all ones plus one retirement becomes 0 with no flag.
- rd_in=0 with reg_write_in=1: valid_out=1, reg_write_out=0, and the instruction still counts.

## Structure
- Shared package riscv_wb_pkg:
  - ResultSrc encodings (RES_ALU, RES_MEM, RES_PC4, RES_CSR).
  - Load funct3 constants (F3_LB … F3_LWU).
- Sub-module load_align (combinational; parameter XLEN; inputs data, offset, funct3; output extended value).
- The top level holds the source mux, the priority register block and the counter.

## Test plan
- Reset then ALU path: rst=1 for 2 cycles → all outputs 0. Then valid, src=00, alu=0x0000_1234, rd=5, regwrite=1 → next cycle result_out=0x1234, rd_out=5, reg_write_out=1, instret=1.
- Load extension: data=0x80FF_7F01, src=01:
  - LB off=3 → 0xFFFF_FF80
  - LBU off=1 → 0x0000_007F
  - LH off=2 → 0xFFFF_80FF
  - LHU off=2 → 0x0000_80FF
  - LW → 0x80FF_7F01
- x0 and invalid: rd=0, regwrite=1, valid=1 → reg_write_out=0, instret+1. The same inputs with valid=0 → valid_out=0 and instret unchanged.
- Stall/flush:
  - stall 3 cycles → outputs frozen.
  - stall+flush in the same cycle → valid_out=0, reg_write_out=0, instret unchanged.
  - the next unstalled valid instruction loads normally.
- Counter wrap: CNT_W=4, retire 17 valid instructions → instret_out=1.
- XLEN=64: data=0x8000_0000_0000_0000, LB off=7 → 0xFFFF_FFFF_FFFF_FF80; LWU off=4 → 0x0000_0000_8000_0000.
